// File: rtl/tm1638_pkg.sv
// Shared constants and state encoding for the TM1638 frame generator.
// A frame is two command words, sixteen display bytes, then display control.
package tm1638_pkg;

  localparam logic [7:0] CMD_DATA_AUTO = 8'h40;
  localparam logic [7:0] CMD_ADDR0     = 8'hC0;
  localparam logic [7:0] CMD_DISP_BASE = 8'h80;

  localparam int WORD_W      = 17;
  localparam int END_BIT     = 16;
  localparam int FRAME_WORDS = 19;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PUSH = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } fg_state_e;

endpackage

// File: rtl/tm1638_frame_gen.sv
// Turns a snapshotted display image into the 19-word TM1638 refresh stream
// and pushes it one word at a time into spi_fifo.
module tm1638_frame_gen
  import tm1638_pkg::*;
#(
  parameter bit INIT_ON_RESET = 1'b1,
  parameter int GAP_CYCLES    = 1
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Update,
  input  logic [63:0]       i_Segments,
  input  logic [7:0]        i_Leds,
  input  logic [2:0]        i_Brightness,
  input  logic              i_Display_On,
  input  logic              i_FIFO_Full,
  output logic              o_Data_Valid,
  output logic [WORD_W-1:0] o_Data,
  output logic              o_Busy,
  output logic              o_Done
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [4:0]    LAST_CNT = 5'(FRAME_WORDS - 1);

  fg_state_e         state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              pend_q, pend_d;
  logic              first_q, first_d;
  logic [63:0]       seg_q, seg_d;
  logic [7:0]        led_q, led_d;
  logic [2:0]        bri_q, bri_d;
  logic              on_q, on_d;
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [WORD_W-1:0] word;
  logic [4:0]        addr;
  logic [2:0]        digit;
  logic [7:0]        disp_byte;
  logic              start_req;

  // cnt 2..17 maps to display address 0..15; odd addresses carry one LED bit.
  always_comb begin
    word      = '0;
    addr      = cnt_q - 5'd2;
    digit     = addr[3:1];
    disp_byte = cnt_q[0] ? {7'b0, led_q[digit]} : seg_q[{digit, 3'b000} +: 8];
    if (cnt_q == 5'd0) begin
      word = {1'b1, 8'h00, CMD_DATA_AUTO};
    end else if (cnt_q == 5'd1) begin
      word = {1'b0, 8'h00, CMD_ADDR0};
    end else if (cnt_q == LAST_CNT) begin
      word = {1'b1, 8'h00, CMD_DISP_BASE | {4'b0, on_q, bri_q}};
    end else begin
      word = {(cnt_q == 5'd17), 8'h00, disp_byte};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    pend_d    = pend_q;
    first_d   = 1'b0;
    seg_d     = seg_q;
    led_d     = led_q;
    bri_d     = bri_q;
    on_d      = on_q;
    valid_d   = 1'b0;
    data_d    = data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    start_req = i_Update | pend_q | (INIT_ON_RESET & first_q);
    case (state_q)
      IDLE: begin
        if (start_req) begin
          seg_d   = i_Segments;
          led_d   = i_Leds;
          bri_d   = i_Brightness;
          on_d    = i_Display_On;
          busy_d  = 1'b1;
          pend_d  = 1'b0;
          cnt_d   = 5'd0;
          state_d = PUSH;
        end
      end
      PUSH: begin
        if (i_Update) pend_d = 1'b1;
        if (!i_FIFO_Full) begin
          valid_d = 1'b1;
          data_d  = word;
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (i_Update) pend_d = 1'b1;
        if (gap_q == GAP_LAST) begin
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + 5'd1;
            state_d = PUSH;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      DONE: begin
        if (i_Update) pend_d = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = 5'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      pend_q  <= 1'b0;
      first_q <= 1'b1;
      seg_q   <= '0;
      led_q   <= '0;
      bri_q   <= '0;
      on_q    <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      first_q <= first_d;
      seg_q   <= seg_d;
      led_q   <= led_d;
      bri_q   <= bri_d;
      on_q    <= on_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_Data_Valid = valid_q;
  assign o_Data       = data_q;
  assign o_Busy       = busy_q;
  assign o_Done       = done_q;

endmodule

// File: tb/tb_tm1638_frame_gen.sv
// Bench for tm1638_frame_gen: instance a auto-starts after reset, instance b
// waits for i_Update and is used for the mid-frame reset sequence.
module tb_tm1638_frame_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst_b_n, upd_a, upd_b;
  logic [63:0] seg;
  logic [7:0]  leds;
  logic [2:0]  bri;
  logic        disp_on;
  logic        force_full, sink_en, sink_full;
  logic        full_a, full_b;
  logic        a_valid, a_busy, a_done, b_valid, b_busy, b_done;
  logic [16:0] a_data, b_data;

  assign full_a = sink_en ? sink_full : force_full;
  assign full_b = 1'b0;

  tm1638_frame_gen #(.INIT_ON_RESET(1'b1), .GAP_CYCLES(1)) dut_a (
    .i_Clk(clk), .i_Rst(rst_n), .i_Update(upd_a), .i_Segments(seg),
    .i_Leds(leds), .i_Brightness(bri), .i_Display_On(disp_on),
    .i_FIFO_Full(full_a), .o_Data_Valid(a_valid), .o_Data(a_data),
    .o_Busy(a_busy), .o_Done(a_done)
  );

  tm1638_frame_gen #(.INIT_ON_RESET(1'b0), .GAP_CYCLES(1)) dut_b (
    .i_Clk(clk), .i_Rst(rst_b_n), .i_Update(upd_b), .i_Segments(seg),
    .i_Leds(leds), .i_Brightness(bri), .i_Display_On(disp_on),
    .i_FIFO_Full(full_b), .o_Data_Valid(b_valid), .o_Data(b_data),
    .o_Busy(b_busy), .o_Done(b_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [16:0] exp_q[$];
  logic [16:0] cap[1024];
  int          pcyc[1024];
  int          cap_n = 0, cyc_n = 0, done_n = 0, done_cyc = 0, upd_cyc = 0;
  logic        prev_valid = 1'b0;
  logic [16:0] mon_exp;
  logic [16:0] b_cap[64];
  int          b_n = 0, b_done_n = 0;
  logic        b_prev = 1'b0;
  int          occ = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Reference: the i-th word of a refresh for the given image.
  function automatic logic [16:0] frame_word(input int i, input logic [63:0] s,
      input logic [7:0] l, input logic [2:0] b, input logic o);
    int n;
    logic [7:0] by;
    if (i == 0) return {1'b1, 8'h00, 8'h40};
    if (i == 1) return {1'b0, 8'h00, 8'hC0};
    if (i == 18) return {1'b1, 8'h00, 8'h80 | ({7'b0, o} << 3) | {5'b0, b}};
    n = i - 2;
    if (n % 2 == 0) by = s[8*(n/2) +: 8];
    else by = {7'b0, l[(n-1)/2]};
    return {(n == 15), 8'h00, by};
  endfunction

  task automatic push_frame_exp(input logic [63:0] s, input logic [7:0] l,
      input logic [2:0] b, input logic o);
    for (int i = 0; i < 19; i++) exp_q.push_back(frame_word(i, s, l, b, o));
  endtask

  task automatic pulse_a();
    @(negedge clk);
    upd_a = 1'b1;
    upd_cyc = cyc_n;
    @(negedge clk);
    upd_a = 1'b0;
  endtask

  task automatic pulse_b();
    @(negedge clk);
    upd_b = 1'b1;
    @(negedge clk);
    upd_b = 1'b0;
  endtask

  task automatic wait_done_a(input int target, input int budget, input string name);
    int k = 0;
    while (done_n < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, done_n, target);
  endtask

  task automatic wait_cap(input int target, input int budget, input string name);
    int k = 0;
    while (cap_n < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (cap_n < target) fail_now(name);
  endtask

  // Monitor for instance a: scoreboard pop, handshake rules, capture.
  always @(posedge clk) begin
    #1;
    cyc_n++;
    if (a_valid === 1'b1) begin
      check("a_no_back_to_back", prev_valid, 0);
      check("a_push_while_full", full_a, 0);
      if (exp_q.size() == 0) begin
        fail_now("a_unexpected_push");
      end else begin
        mon_exp = exp_q.pop_front();
        check("a_word", a_data, mon_exp);
      end
      if (cap_n < 1024) begin
        cap[cap_n]  = a_data;
        pcyc[cap_n] = cyc_n;
      end
      cap_n++;
    end
    prev_valid = a_valid;
    if (a_done === 1'b1) begin
      done_n++;
      done_cyc = cyc_n;
    end
  end

  always @(posedge clk) begin
    #1;
    if (b_valid === 1'b1) begin
      check("b_no_back_to_back", b_prev, 0);
      if (b_n < 64) b_cap[b_n] = b_data;
      b_n++;
    end
    b_prev = b_valid;
    if (b_done === 1'b1) b_done_n++;
  end

  // Depth-2 sink with a registered full flag and random draining.
  always @(negedge clk) begin
    if (sink_en) begin
      if (a_valid === 1'b1) begin
        occ++;
        check("a_fifo_overflow", (occ > 2), 0);
      end
      if (occ > 0 && $urandom_range(0, 2) == 0) occ--;
      sink_full = (occ >= 2);
    end else begin
      occ = 0;
      sink_full = 1'b0;
    end
  end

  typedef struct {
    logic [63:0] s;
    logic [7:0]  l;
    logic [2:0]  b;
    logic        o;
    logic [16:0] w2, w3, w16, w17, w18;
  } vec_t;

  vec_t vt[4];

  initial begin
    int base, dn, b_base, k;
    logic [16:0] held;

    vt[0] = '{64'h0123456789ABCDEF, 8'hA5, 3'd7, 1'b1, 17'h000EF, 17'h00001, 17'h00001, 17'h10001, 17'h1008F};
    vt[1] = '{64'h0, 8'h00, 3'd0, 1'b0, 17'h00000, 17'h00000, 17'h00000, 17'h10000, 17'h10080};
    vt[2] = '{64'h8000000000000055, 8'h7E, 3'd3, 1'b0, 17'h00055, 17'h00000, 17'h00080, 17'h10000, 17'h10083};
    vt[3] = '{64'hFFFFFFFFFFFFFFFF, 8'hFF, 3'd5, 1'b1, 17'h000FF, 17'h00001, 17'h000FF, 17'h10001, 17'h1008D};

    rst_n = 1'b0; rst_b_n = 1'b0; upd_a = 1'b0; upd_b = 1'b0;
    seg = '0; leds = '0; bri = '0; disp_on = 1'b0;
    force_full = 1'b0; sink_en = 1'b0;

    // Reset state, then the automatic all-zero frame.
    push_frame_exp(64'h0, 8'h00, 3'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_valid", a_valid, 0);
    check("rst_data", a_data, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    rst_n = 1'b1;
    rst_b_n = 1'b1;
    wait_done_a(1, 100, "t1_done");
    check("t1_push_count", cap_n, 19);
    for (int i = 1; i < 19; i++) check("t1_spacing", pcyc[i] - pcyc[i-1], 2);
    check("t1_w0", cap[0], 17'h10040);
    check("t1_w1", cap[1], 17'h000C0);
    check("t1_w17", cap[17], 17'h10000);
    check("t1_w18", cap[18], 17'h10080);
    repeat (10) @(negedge clk);
    check("t1_done_once", done_n, 1);
    check("t1_busy_clear", a_busy, 0);
    check("b_idle_without_update", b_n, 0);

    // Table of images with hand-computed key words.
    for (int v = 0; v < 4; v++) begin
      seg = vt[v].s; leds = vt[v].l; bri = vt[v].b; disp_on = vt[v].o;
      base = cap_n;
      dn = done_n;
      push_frame_exp(seg, leds, bri, disp_on);
      pulse_a();
      wait_done_a(dn + 1, 100, "tv_done");
      check("tv_frame_time", done_cyc - upd_cyc, 40);
      check("tv_count", cap_n - base, 19);
      check("tv_w2", cap[base+2], vt[v].w2);
      check("tv_w3", cap[base+3], vt[v].w3);
      check("tv_w16", cap[base+16], vt[v].w16);
      check("tv_w17", cap[base+17], vt[v].w17);
      check("tv_w18", cap[base+18], vt[v].w18);
      if (v == 0) check("tv_w5", cap[base+5], 17'h00000);
      repeat (3) @(negedge clk);
    end

    // FIFO full around W5: no push, data held, W5 on release.
    seg = vt[0].s; leds = vt[0].l; bri = vt[0].b; disp_on = vt[0].o;
    base = cap_n;
    dn = done_n;
    push_frame_exp(seg, leds, bri, disp_on);
    pulse_a();
    wait_cap(base + 5, 100, "t3_reach_w4");
    force_full = 1'b1;
    held = a_data;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("t3_no_valid_full", a_valid, 0);
      check("t3_data_held", a_data, held);
    end
    force_full = 1'b0;
    @(negedge clk);
    check("t3_w5_valid", a_valid, 1);
    check("t3_w5_data", a_data, frame_word(5, seg, leds, bri, disp_on));
    wait_done_a(dn + 1, 100, "t3_done");

    // Collapsing pending requests and mid-frame image change.
    repeat (3) @(negedge clk);
    seg = vt[0].s; leds = 8'hA5; bri = 3'd2; disp_on = 1'b1;
    base = cap_n;
    dn = done_n;
    push_frame_exp(seg, leds, bri, disp_on);
    pulse_a();
    wait_cap(base + 6, 100, "t5_reach_w5");
    pulse_a();
    leds = 8'hFF;
    push_frame_exp(seg, 8'hFF, bri, disp_on);
    pulse_a();
    pulse_a();
    wait_done_a(dn + 2, 200, "t5_two_frames");
    repeat (60) @(negedge clk);
    check("t5_no_third_frame", done_n, dn + 2);
    check("t5_push_count", cap_n - base, 38);
    check("t5_exp_empty", exp_q.size(), 0);
    check("t5_old_led0", cap[base+3], 17'h00001);
    check("t5_old_led1", cap[base+5], 17'h00000);
    check("t5_new_led0", cap[base+19+3], 17'h00001);
    check("t5_new_led1", cap[base+19+5], 17'h00001);
    check("t5_new_led7", cap[base+19+17], 17'h10001);

    // i_Update landing in the DONE cycle becomes a pending frame.
    base = cap_n;
    dn = done_n;
    push_frame_exp(seg, leds, bri, disp_on);
    pulse_a();
    wait_cap(base + 19, 100, "t5b_reach_w18");
    @(negedge clk);
    check("t5b_busy_in_done", a_busy, 1);
    upd_a = 1'b1;
    leds = 8'h3C;
    push_frame_exp(seg, 8'h3C, bri, disp_on);
    @(negedge clk);
    upd_a = 1'b0;
    wait_done_a(dn + 2, 200, "t5b_pending_frame");
    check("t5b_push_count", cap_n - base, 38);

    // Random images against a back-pressuring sink.
    sink_en = 1'b1;
    for (int r = 0; r < 6; r++) begin
      seg = {$urandom(), $urandom()};
      leds = 8'($urandom());
      bri = 3'($urandom_range(0, 7));
      disp_on = 1'($urandom_range(0, 1));
      dn = done_n;
      push_frame_exp(seg, leds, bri, disp_on);
      pulse_a();
      repeat ($urandom_range(1, 20)) @(negedge clk);
      seg = {$urandom(), $urandom()};
      leds = 8'($urandom());
      bri = 3'($urandom_range(0, 7));
      wait_done_a(dn + 1, 400, "tr_done");
      repeat (2) @(negedge clk);
    end
    sink_en = 1'b0;
    repeat (5) @(negedge clk);
    check("tr_exp_empty", exp_q.size(), 0);

    // Asynchronous reset in the W10 gap on instance b.
    seg = vt[3].s; leds = vt[0].l; bri = vt[2].b; disp_on = 1'b1;
    pulse_b();
    k = 0;
    while (b_n < 11 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (b_n < 11) fail_now("t6_reach_w10");
    check("t6_busy_before", b_busy, 1);
    #2 rst_b_n = 1'b0;
    #1;
    check("t6_rst_valid", b_valid, 0);
    check("t6_rst_data", b_data, 0);
    check("t6_rst_busy", b_busy, 0);
    check("t6_rst_done", b_done, 0);
    @(negedge clk);
    @(negedge clk);
    rst_b_n = 1'b1;
    b_base = b_n;
    repeat (30) @(negedge clk);
    check("t6_no_push_after_release", b_n, b_base);
    check("t6_no_done_after_release", b_done_n, 0);
    pulse_b();
    k = 0;
    while (b_done_n < 1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("t6_frame_done", b_done_n, 1);
    check("t6_frame_count", b_n - b_base, 19);
    for (int i = 0; i < 19; i++)
      check("t6_word", b_cap[b_base+i], frame_word(i, seg, leds, bri, disp_on));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tm1638_frame_gen.md
Name: tm1638_frame_gen

Overview:
Upstream producer for spi_fifo. It converts a parallel display image (8 seven-segment digits, 8 LEDs, brightness, on/off) into the TM1638 command/data word stream and pushes it into spi_fifo through the o_Data_Valid/i_FIFO_Full handshake. One frame is a full refresh: data-command, address-command plus 16 display bytes, then display-control.

Parameters:
INIT_ON_RESET, 1, when 1 a frame is sent automatically after reset release, without waiting for i_Update.
GAP_CYCLES, 1, idle cycles after each push (min 1) so the registered i_FIFO_Full can update before the next push decision.

Ports:
i_Clk  in  1  system clock; all logic on rising edge.
i_Rst  in  1  reset; one clock, asynchronous assert, active-low (0 = reset).
i_Update  in  1  single-cycle request to send a frame.
i_Segments  in  64  digit k segments = i_Segments[8k+7:8k], k=0..7, bit0 = seg a, bit7 = dp.
i_Leds  in  8  LED k on when i_Leds[k]=1.
i_Brightness  in  3  TM1638 pulse width 0..7.
i_Display_On  in  1  display enable.
i_FIFO_Full  in  1  from spi_fifo o_FIFO_Full.
o_Data_Valid  out  1  one-cycle push strobe to spi_fifo i_Data_Valid.
o_Data  out  17  word to spi_fifo i_Data.
o_Busy  out  1  frame in progress.
o_Done  out  1  one-cycle pulse after the last word of a frame is pushed.

Behaviour:
- Word format: [16] = END, which releases STB after this byte. [15:8] = 0. [7:0] = byte.
- Frame, 19 words in order:
  - W0 = {1,8'h00,8'h40}: write data, auto-increment.
  - W1 = {0,8'h00,8'hC0}: address 0.
  - W2..W17: address n = 0..15; even n = digit n/2 segments, odd n = {7'b0, LED (n-1)/2}. END=1 only on W17.
  - W18 = {1,8'h00, 8'h80 | Display_On<<3 | Brightness}.
- Reset (i_Rst=0): o_Data_Valid=0, o_Data=0, o_Busy=0, o_Done=0, state IDLE, word counter 0, pending flag 0, snapshot registers 0.
- States:
  - IDLE: on i_Update or pending, or on first cycle after reset release when INIT_ON_RESET=1, snapshot all image inputs, set o_Busy=1, go to PUSH.
  - PUSH: if i_FIFO_Full=0, register o_Data_Valid=1 and o_Data = word[cnt] for exactly one cycle, then go to GAP. If full, hold in PUSH with o_Data_Valid=0.
  - GAP: hold GAP_CYCLES cycles. If cnt==18, go to DONE; else cnt++ and go to PUSH.
  - DONE: pulse o_Done, clear o_Busy, cnt=0, go to IDLE.
- o_Data is registered and held stable between pushes; it changes only when o_Data_Valid rises.
- Minimum frame time = 19*(1+GAP_CYCLES)+2 cycles. With GAP_CYCLES=1, that is 40 cycles from i_Update to o_Done.
- Image inputs are sampled only at frame start; changes mid-frame do not affect the frame in flight.
- i_Update while o_Busy=1 sets pending. Pending is a single slot (collapsing) and is cleared on the next frame start. i_Update coincident with DONE is captured as pending.
- i_FIFO_Full rising during GAP has no effect; it is re-evaluated in PUSH.
- Reset mid-frame aborts immediately, with no further pushes. Partial frames are not resumed.
- o_Data_Valid is never asserted in two consecutive cycles.

Decomposition:
- Package tm1638_pkg holds:
  - CMD_DATA_AUTO = 8'h40, CMD_ADDR0 = 8'hC0, CMD_DISP_BASE = 8'h80.
  - WORD_W = 17, END_BIT = 16, FRAME_WORDS = 19.
  - Frame-generator state enum {IDLE, PUSH, GAP, DONE}.
- No sub-module: FSM, 5-bit counter and word mux live in one module. spi_fifo consumes its output unchanged.

Test Plan:
1. Reset, INIT_ON_RESET=1, inputs all zero, FIFO never full. Required response:
   - exactly 19 pushes, 2 cycles apart;
   - words 17'h10040, 17'h000C0, sixteen data words (only the last with END=1: 17'h10000), then 17'h10080;
   - o_Done pulses once.
2. i_Segments = 64'h0123456789ABCDEF, i_Leds = 8'hA5, i_Brightness = 7, i_Display_On = 1, pulse i_Update. Required response:
   - W2 = 17'h000EF, W3 = 17'h00001, W5 = 17'h00000;
   - W17 = 17'h10001;
   - W18 = 17'h1008F.
3. i_FIFO_Full held 1 for 10 cycles from W5's PUSH. Required response:
   - no o_Data_Valid while full;
   - W5 is pushed on the first cycle full is 0;
   - o_Data stays unchanged throughout.
4. Drive spi_fifo (FIFO_DEPTH=2, SPI_CYCLES=0) as the real sink. Required response:
   - no push while o_FIFO_Full=1;
   - the decoded SPI byte sequence equals the 19 frame bytes;
   - STB rises after W0, W17 and W18.
5. Pulse i_Update 3 times during a frame, change i_Leds to 8'hFF mid-frame. Required response:
   - the current frame keeps the old LED bytes;
   - exactly one further frame follows, with odd-address bytes = 8'h01.
6. Assert i_Rst=0 asynchronously mid-W10 GAP. Required response:
   - all outputs are 0 within the same cycle, before the next edge;
   - after release with INIT_ON_RESET=0, nothing is pushed until i_Update.
